// File: rtl/sha256_msg_schedule_if.sv
// Load/stream bundle for the SHA-256 message-schedule expander.
// The slave modport is the expander; the master side loads blocks and consumes words.
interface sha256_msg_schedule_if;
  logic         start;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         busy;
  logic         done;

  modport master (output start, block_in, w_ready,
                  input  w_valid, w_out, w_idx, busy, done);
  modport slave  (input  start, block_in, w_ready,
                  output w_valid, w_out, w_idx, busy, done);
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..NUM_WORDS-1],
// one word per accepted handshake, expanding W[16..] from a 16-word sliding window.
module sha256_msg_schedule #(
  parameter int NUM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sha256_msg_schedule_if.slave bus
);
  localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [15:0][31:0] r;
  logic [5:0]        t;
  logic              done_q;
  logic              hs, last;
  logic [31:0]       w_new;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  assign hs    = (state == RUN) && bus.w_ready;
  assign last  = (t == LAST);
  // window slot 15 receives W[t+16]; slots 0/1/9/14 are W[t], W[t+1], W[t+9], W[t+14]
  assign w_new = sig1(r[14]) + r[9] + sig0(r[1]) + r[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (hs && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      t      <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && last;
      if (state == IDLE && bus.start) begin
        for (int i = 0; i < 16; i++) r[i] <= bus.block_in[511-32*i -: 32];
        t <= '0;
      end else if (hs && !last) begin
        r <= {w_new, r[15:1]};
        t <= t + 6'd1;
      end
    end
  end

  // Every output is a direct register tap; w_ready never reaches them combinationally.
  always_comb begin
    bus.w_valid = (state == RUN);
    bus.busy    = (state == RUN);
    bus.w_out   = r[0];
    bus.w_idx   = t;
    bus.done    = done_q;
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: expected words are queued at load time
// from an independent W[t] recurrence and popped on every handshake.
module tb_sha256_msg_schedule;
  localparam int NW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_schedule_if bus();
  sha256_msg_schedule #(.NUM_WORDS(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] rx[64];
  logic [31:0] acc = '0;
  bit          prev_hs_last = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_out = '0;
  logic [5:0]  prev_idx = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w[64];
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    for (int i = 0; i < NW; i++) q.push_back('{w: w[i], idx: 6'(i)});
  endtask

  // w_ready driver: always-ready or pseudo-random toggling
  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.w_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake scoreboard, done timing, stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs_last = 0;
      prev_stall   = 0;
    end else begin
      exp_t e;
      chk("done", bus.done, prev_hs_last);
      if (bus.done) begin
        done_cnt++;
        chk("vld_in_done", bus.w_valid, 0);
      end
      if (prev_stall) begin
        chk("stall_vld", bus.w_valid, 1);
        chk("stall_out", bus.w_out, prev_out);
        chk("stall_idx", bus.w_idx, prev_idx);
      end
      if (bus.w_valid && bus.w_ready) begin
        if (q.size() == 0) chk("underflow", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("w_out", bus.w_out, e.w);
          chk("w_idx", bus.w_idx, e.idx);
        end
        rx[bus.w_idx] = bus.w_out;
        acc = acc | bus.w_out;
        hs_cnt++;
      end
      prev_hs_last = bus.w_valid && bus.w_ready && (bus.w_idx == 6'(NW-1));
      prev_stall   = bus.w_valid && !bus.w_ready;
      prev_out     = bus.w_out;
      prev_idx     = bus.w_idx;
    end
  end

  task automatic load(input logic [511:0] b);
    @(negedge clk);
    bus.block_in = b;
    bus.start    = 1'b1;
    push_block(b);
    @(negedge clk);
    bus.start = 1'b0;
    chk("latency", bus.w_valid, 1);
    chk("w0_idx", bus.w_idx, 0);
    chk("w0", bus.w_out, b[511:480]);
  endtask

  task automatic wait_idx(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.w_valid && bus.w_idx == 6'(i)) && n < 1000);
    chk("wait_idx", n < 1000, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 2000);
    chk("wait_done", bus.done, 1);
  endtask

  logic [511:0] abc, blk_a, blk_b, blk_c, b1, b2;

  initial begin
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      blk_a[511-32*i -: 32] = $urandom;
      blk_b[511-32*i -: 32] = $urandom;
      blk_c[511-32*i -: 32] = $urandom;
      b1[511-32*i -: 32]    = $urandom;
      b2[511-32*i -: 32]    = $urandom;
    end
    bus.start = 1'b0;
    bus.block_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_vld", bus.w_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out", bus.w_out, 0);
    chk("rst_idx", bus.w_idx, 0);
    rst_n = 1'b1;

    // 1: "abc" block, always ready
    hs_cnt = 0; done_cnt = 0;
    load(abc);
    wait_done();
    repeat (3) @(negedge clk);
    chk("s1_cnt", hs_cnt, NW);
    chk("s1_q", q.size(), 0);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_w15", rx[15], 32'h00000018);
    chk("s1_w16", rx[16], 32'h61626380);
    chk("s1_w17", rx[17], 32'h000F0000);
    chk("s1_idle_busy", bus.busy, 0);

    // 2: same block with random stalls
    rdy_mode = 1; hs_cnt = 0;
    load(abc);
    wait_done();
    chk("s2_cnt", hs_cnt, NW);
    chk("s2_q", q.size(), 0);

    // 3: all-zero block
    rdy_mode = 0; hs_cnt = 0; acc = '0;
    load('0);
    wait_done();
    chk("s3_cnt", hs_cnt, NW);
    chk("s3_zero", acc, 0);

    // 4: start with another block mid-run is ignored
    rdy_mode = 1; hs_cnt = 0;
    load(blk_a);
    wait_idx(10);
    bus.block_in = blk_b;
    bus.start    = 1'b1;
    @(negedge clk);
    chk("s4_busy", bus.busy, 1);
    bus.start    = 1'b0;
    bus.block_in = blk_a;
    wait_done();
    chk("s4_cnt", hs_cnt, NW);
    chk("s4_q", q.size(), 0);

    // 5: asynchronous reset mid-block, then replay
    rdy_mode = 0;
    load(blk_b);
    wait_idx(30);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("s5_vld", bus.w_valid, 0);
    chk("s5_busy", bus.busy, 0);
    chk("s5_done", bus.done, 0);
    chk("s5_out", bus.w_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hs_cnt = 0;
    load(blk_c);
    wait_done();
    chk("s5_cnt", hs_cnt, NW);
    chk("s5_q", q.size(), 0);

    // 6: start held through the done cycle loads the next block
    hs_cnt = 0;
    @(negedge clk);
    bus.block_in = b1;
    bus.start    = 1'b1;
    push_block(b1);
    push_block(b2);
    @(negedge clk);
    bus.block_in = b2;
    wait_done();
    chk("s6_gap0", bus.w_valid, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("s6_gap_vld", bus.w_valid, 1);
    chk("s6_gap_idx", bus.w_idx, 0);
    chk("s6_gap_w0", bus.w_out, b2[511:480]);
    wait_done();
    chk("s6_cnt", hs_cnt, 2*NW);
    chk("s6_q", q.size(), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
